// File: rtl/ethernet_mmio_arbiter.sv
// Round-robin arbiter sharing one synchronous-read MMIO port between two requesters.
// Credits reserve a response FIFO slot before issue, so the controller port never stalls.
module ethernet_mmio_arbiter #(
  parameter int data_width_p  = 32,
  parameter int addr_width_p  = 32,
  parameter int mask_width_lp = data_width_p >> 3,
  parameter int rsp_els_p     = 2
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic [1:0]                   req_v_i,
  input  logic [1:0]                   req_w_i,
  input  logic [2*addr_width_p-1:0]    req_addr_i,
  input  logic [2*data_width_p-1:0]    req_data_i,
  input  logic [2*mask_width_lp-1:0]   req_wmask_i,
  output logic [1:0]                   req_ready_and_o,
  output logic [1:0]                   rsp_v_o,
  output logic [2*data_width_p-1:0]    rsp_data_o,
  input  logic [1:0]                   rsp_ready_and_i,
  output logic [addr_width_p-1:0]      addr_o,
  output logic                         write_en_o,
  output logic                         read_en_o,
  output logic [mask_width_lp-1:0]     write_mask_o,
  output logic [data_width_p-1:0]      write_data_o,
  input  logic [data_width_p-1:0]      read_data_i,
  output logic                         idle_o
);

  localparam int cred_w_lp = $clog2(rsp_els_p + 1);
  localparam int ptr_w_lp  = (rsp_els_p > 1) ? $clog2(rsp_els_p) : 1;
  localparam logic [cred_w_lp-1:0] cred_max_lp = cred_w_lp'(rsp_els_p);
  localparam logic [ptr_w_lp-1:0]  ptr_last_lp = ptr_w_lp'(rsp_els_p - 1);

  logic [cred_w_lp-1:0]    credit_q [2];
  logic [cred_w_lp-1:0]    credit_d [2];
  logic                    last_q, last_d;
  logic                    s1_v_q, s1_v_d;
  logic                    s1_id_q, s1_id_d;
  logic                    s1_w_q, s1_w_d;
  logic [data_width_p-1:0] mem_q [2][rsp_els_p];
  logic [data_width_p-1:0] mem_d [2][rsp_els_p];
  logic [ptr_w_lp-1:0]     rd_ptr_q [2];
  logic [ptr_w_lp-1:0]     rd_ptr_d [2];
  logic [ptr_w_lp-1:0]     wr_ptr_q [2];
  logic [ptr_w_lp-1:0]     wr_ptr_d [2];
  logic [cred_w_lp-1:0]    cnt_q [2];
  logic [cred_w_lp-1:0]    cnt_d [2];

  logic [1:0]              elig;
  logic [1:0]              grant;
  logic                    gnt_id;
  logic                    any_grant;
  logic [1:0]              push;
  logic [1:0]              pop;
  logic [data_width_p-1:0] push_data;
  logic [mask_width_lp-1:0] sel_mask;

  function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
    return (p == ptr_last_lp) ? '0 : p + 1'b1;
  endfunction

  // Tie-break alternates on last_q; with a single eligible requester it simply wins.
  always_comb begin
    elig[0] = reset_n_i & req_v_i[0] & (credit_q[0] != '0);
    elig[1] = reset_n_i & req_v_i[1] & (credit_q[1] != '0);
    grant   = elig;
    if (&elig) begin
      grant = last_q ? 2'b01 : 2'b10;
    end
    gnt_id    = grant[1];
    any_grant = |grant;
  end

  assign req_ready_and_o = grant;
  assign addr_o       = gnt_id ? req_addr_i[2*addr_width_p-1:addr_width_p] : req_addr_i[addr_width_p-1:0];
  assign write_data_o = gnt_id ? req_data_i[2*data_width_p-1:data_width_p] : req_data_i[data_width_p-1:0];
  assign sel_mask     = gnt_id ? req_wmask_i[2*mask_width_lp-1:mask_width_lp] : req_wmask_i[mask_width_lp-1:0];
  assign write_en_o   = any_grant & req_w_i[gnt_id];
  assign read_en_o    = any_grant & ~req_w_i[gnt_id];
  assign write_mask_o = write_en_o ? sel_mask : '0;

  assign rsp_v_o[0] = reset_n_i & (cnt_q[0] != '0);
  assign rsp_v_o[1] = reset_n_i & (cnt_q[1] != '0);
  assign rsp_data_o = {mem_q[1][rd_ptr_q[1]], mem_q[0][rd_ptr_q[0]]};
  assign pop        = rsp_v_o & rsp_ready_and_i;
  assign push       = {s1_v_q & s1_id_q, s1_v_q & ~s1_id_q};
  assign push_data  = s1_w_q ? '0 : read_data_i;
  assign idle_o     = ~s1_v_q & ~|rsp_v_o;

  always_comb begin
    last_d   = any_grant ? gnt_id : last_q;
    s1_v_d   = any_grant;
    s1_id_d  = gnt_id;
    s1_w_d   = req_w_i[gnt_id];
    credit_d = credit_q;
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    for (int i = 0; i < 2; i++) begin
      case ({grant[i], pop[i]})
        2'b10:   credit_d[i] = credit_q[i] - 1'b1;
        2'b01:   credit_d[i] = credit_q[i] + 1'b1;
        default: credit_d[i] = credit_q[i];
      endcase
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = push_data;
        wr_ptr_d[i]           = ptr_inc(wr_ptr_q[i]);
      end
      if (pop[i]) begin
        rd_ptr_d[i] = ptr_inc(rd_ptr_q[i]);
      end
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 1'b1;
        2'b01:   cnt_d[i] = cnt_q[i] - 1'b1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end
  end

  // Reset drops stage 1 without pushing, so an in-flight read_data_i is discarded.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      last_q  <= 1'b1;
      s1_v_q  <= 1'b0;
      s1_id_q <= 1'b0;
      s1_w_q  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        credit_q[i] <= cred_max_lp;
        rd_ptr_q[i] <= '0;
        wr_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
    end else begin
      last_q   <= last_d;
      s1_v_q   <= s1_v_d;
      s1_id_q  <= s1_id_d;
      s1_w_q   <= s1_w_d;
      credit_q <= credit_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      for (int i = 0; i < 2; i++) begin
        if (push[i]) begin
          assert (cnt_q[i] != cred_max_lp) else $error("response FIFO %0d overflow", i);
        end
        if (pop[i] && !grant[i]) begin
          assert (credit_q[i] != cred_max_lp) else $error("credit %0d overflow", i);
        end
        if (grant[i] && !pop[i]) begin
          assert (credit_q[i] != '0) else $error("credit %0d underflow", i);
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_ethernet_mmio_arbiter.sv
// Directed bench for ethernet_mmio_arbiter: a queue-based reference model checked every
// cycle, an emulated sync-read controller, and literal expectations for each scenario.
module tb_ethernet_mmio_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int MW  = 4;
  localparam int ELS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetN;
  logic [1:0]    reqV, reqW, rspRdy;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] data0, data1;
  logic [MW-1:0] mask0, mask1;

  logic [1:0]      reqRdy, rspV;
  logic [2*DW-1:0] rspData;
  logic [AW-1:0]   addrO;
  logic            wen, ren, idle;
  logic [MW-1:0]   wmaskO;
  logic [DW-1:0]   wdataO, readData;

  ethernet_mmio_arbiter #(
    .data_width_p(DW), .addr_width_p(AW), .mask_width_lp(MW), .rsp_els_p(ELS)
  ) dut (
    .clk_i(clk), .reset_n_i(resetN),
    .req_v_i(reqV), .req_w_i(reqW),
    .req_addr_i({addr1, addr0}), .req_data_i({data1, data0}), .req_wmask_i({mask1, mask0}),
    .req_ready_and_o(reqRdy), .rsp_v_o(rspV), .rsp_data_o(rspData), .rsp_ready_and_i(rspRdy),
    .addr_o(addrO), .write_en_o(wen), .read_en_o(ren), .write_mask_o(wmaskO),
    .write_data_o(wdataO), .read_data_i(readData), .idle_o(idle)
  );

  // Controller contents as seen by reads: a fixed function of the address.
  function automatic logic [31:0] ctrlFn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Emulated controller: data appears the cycle after the read strobe, garbage otherwise.
  logic          ctrlRd = 1'b0;
  logic [AW-1:0] ctrlAddr = '0;
  always @(posedge clk) begin
    ctrlRd <= ren;
    if (ren) ctrlAddr <= addrO;
  end
  assign readData = ctrlRd ? ctrlFn(ctrlAddr) : 32'hBAD0BAD0;

  int nCmp = 0;
  int nBad = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] popLog0[$];
  int          grantLog[$];
  int          grantCount[2];
  bit          mS1V;
  int          mS1Id;
  bit          mS1W;
  logic [31:0] mS1Addr;
  int          mLast;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [1:0] w, input logic [1:0] rdy);
    reqV   = v;
    reqW   = w;
    rspRdy = rdy;
  endtask

  task automatic modelReset();
    q0.delete();
    q1.delete();
    mS1V  = 0;
    mS1Id = 0;
    mS1W  = 0;
    mLast = 1;
  endtask

  // Reference: credit is the free response space; each request occupies one slot from
  // acceptance until its response is consumed.
  task automatic modelCompare();
    int s0, s1, c0, c1, g;
    bit e0, e1;
    logic [1:0] expRdy, expV;
    logic [31:0] a, val;
    if (!resetN) begin
      checkOutput("rst_ready", {62'd0, reqRdy}, 64'd0);
      checkOutput("rst_strobes", {62'd0, wen, ren}, 64'd0);
      checkOutput("rst_rsp_v", {62'd0, rspV}, 64'd0);
      modelReset();
      return;
    end
    s0 = q0.size();
    s1 = q1.size();
    c0 = ELS - ((mS1V && mS1Id == 0) ? 1 : 0) - s0;
    c1 = ELS - ((mS1V && mS1Id == 1) ? 1 : 0) - s1;
    e0 = reqV[0] && (c0 > 0);
    e1 = reqV[1] && (c1 > 0);
    if (e0 && e1) g = (mLast == 1) ? 0 : 1;
    else if (e0)  g = 0;
    else if (e1)  g = 1;
    else          g = -1;
    expRdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
    checkOutput("ready", {62'd0, reqRdy}, {62'd0, expRdy});
    if (g < 0) begin
      checkOutput("strobes", {62'd0, wen, ren}, 64'd0);
    end else begin
      a = (g == 1) ? addr1 : addr0;
      checkOutput("strobes", {62'd0, wen, ren}, reqW[g] ? 64'd2 : 64'd1);
      checkOutput("addr", {32'd0, addrO}, {32'd0, a});
      if (reqW[g]) begin
        checkOutput("wdata", {32'd0, wdataO}, {32'd0, (g == 1) ? data1 : data0});
        checkOutput("wmask", {60'd0, wmaskO}, {60'd0, (g == 1) ? mask1 : mask0});
      end else begin
        checkOutput("wmask_rd", {60'd0, wmaskO}, 64'd0);
      end
    end
    expV = {s1 > 0, s0 > 0};
    checkOutput("rsp_v", {62'd0, rspV}, {62'd0, expV});
    if (s0 > 0) checkOutput("rsp_data0", {32'd0, rspData[31:0]}, {32'd0, q0[0]});
    if (s1 > 0) checkOutput("rsp_data1", {32'd0, rspData[63:32]}, {32'd0, q1[0]});
    checkOutput("idle", {63'd0, idle}, {63'd0, (!mS1V && s0 == 0 && s1 == 0)});
    if (expV[0] && rspRdy[0]) begin
      popLog0.push_back(q0[0]);
      q0.delete(0);
    end
    if (expV[1] && rspRdy[1]) q1.delete(0);
    if (mS1V) begin
      val = mS1W ? 32'd0 : ctrlFn(mS1Addr);
      if (mS1Id == 0) q0.push_back(val);
      else            q1.push_back(val);
    end
    mS1V = (g >= 0);
    if (g >= 0) begin
      mS1Id   = g;
      mS1W    = reqW[g];
      mS1Addr = (g == 1) ? addr1 : addr0;
      mLast   = g;
      grantCount[g]++;
      grantLog.push_back(g);
    end
  endtask

  task automatic step();
    @(negedge clk);
    modelCompare();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int base0, base1, acc;
    resetN = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b00);
    addr0 = '0; addr1 = '0; data0 = '0; data1 = '0; mask0 = '0; mask1 = '0;
    grantCount = '{0, 0};
    modelReset();
    repeat (3) step();
    resetN = 1'b1;
    step();
    checkOutput("reset_idle", {63'd0, idle}, 64'd1);
    checkOutput("reset_rsp_v", {62'd0, rspV}, 64'd0);

    $display("[TB] single read");
    addr0 = 32'h10;
    applyStimulus(2'b01, 2'b00, 2'b00);
    #1;
    checkOutput("t1_ready", {62'd0, reqRdy}, 64'd1);
    checkOutput("t1_read_en", {63'd0, ren}, 64'd1);
    step();
    applyStimulus(2'b00, 2'b00, 2'b00);
    step();
    checkOutput("t1_rsp_v", {62'd0, rspV}, 64'd1);
    checkOutput("t1_rsp_data", {32'd0, rspData[31:0]}, 64'hDEADBEEF);
    applyStimulus(2'b00, 2'b00, 2'b01);
    step();
    applyStimulus(2'b00, 2'b00, 2'b00);
    checkOutput("t1_idle_after_pop", {63'd0, idle}, 64'd1);

    $display("[TB] round robin");
    addr0 = 32'h200; addr1 = 32'h300;
    grantLog.delete();
    applyStimulus(2'b11, 2'b00, 2'b11);
    repeat (10) step();
    checkOutput("t2_grants", grantLog.size(), 64'd10);
    for (int k = 0; k < grantLog.size(); k++)
      checkOutput("t2_alternate", grantLog[k], (k % 2 == 0) ? 64'd1 : 64'd0);
    applyStimulus(2'b00, 2'b00, 2'b11);
    repeat (4) step();

    $display("[TB] credit stall");
    addr1 = 32'h30; data1 = 32'hCAFEF00D; mask1 = 4'hF;
    base1 = grantCount[1];
    applyStimulus(2'b10, 2'b10, 2'b01);
    repeat (5) step();
    checkOutput("t3_two_accepted", grantCount[1] - base1, 64'd2);
    checkOutput("t3_rsp_v1", {63'd0, rspV[1]}, 64'd1);
    checkOutput("t3_ack_data", {32'd0, rspData[63:32]}, 64'd0);
    applyStimulus(2'b10, 2'b10, 2'b11);
    step();
    checkOutput("t3_held_during_pop", grantCount[1] - base1, 64'd2);
    applyStimulus(2'b10, 2'b10, 2'b01);
    step();
    checkOutput("t3_third_accepted", grantCount[1] - base1, 64'd3);
    applyStimulus(2'b00, 2'b00, 2'b11);
    repeat (4) step();

    $display("[TB] isolation");
    addr1 = 32'h400;
    popLog0.delete();
    base1 = grantCount[1];
    acc = 0;
    for (int cyc = 0; cyc < 60 && acc < 8; cyc++) begin
      addr0 = 32'h100 + 32'(4 * acc);
      applyStimulus(2'b11, 2'b00, 2'b01);
      base0 = grantCount[0];
      step();
      if (grantCount[0] != base0) acc++;
    end
    applyStimulus(2'b00, 2'b00, 2'b01);
    checkOutput("t4_accepted", acc, 64'd8);
    repeat (6) step();
    checkOutput("t4_completed", popLog0.size(), 64'd8);
    if (popLog0.size() == 8) begin
      checkOutput("t4_first_data", {32'd0, popLog0[0]}, 64'h5B5A0100);
      checkOutput("t4_last_data", {32'd0, popLog0[7]}, 64'h5B46011C);
    end
    checkOutput("t4_req1_stalled", grantCount[1] - base1, 64'd2);
    checkOutput("t4_req1_held", {63'd0, rspV[1]}, 64'd1);
    applyStimulus(2'b00, 2'b00, 2'b11);
    repeat (4) step();

    $display("[TB] write path");
    addr0 = 32'h20; data0 = 32'h12345678; mask0 = 4'b0011;
    applyStimulus(2'b01, 2'b01, 2'b00);
    #1;
    checkOutput("t5_write_en", {63'd0, wen}, 64'd1);
    checkOutput("t5_mask", {60'd0, wmaskO}, 64'h3);
    checkOutput("t5_addr", {32'd0, addrO}, 64'h20);
    step();
    applyStimulus(2'b00, 2'b00, 2'b00);
    step();
    checkOutput("t5_ack_v", {62'd0, rspV}, 64'd1);
    checkOutput("t5_ack_data", {32'd0, rspData[31:0]}, 64'd0);
    applyStimulus(2'b00, 2'b00, 2'b01);
    step();

    $display("[TB] reset mid-flight");
    addr0 = 32'h40;
    applyStimulus(2'b01, 2'b00, 2'b11);
    step();
    resetN = 1'b0;
    applyStimulus(2'b00, 2'b00, 2'b11);
    step();
    step();
    resetN = 1'b1;
    step();
    checkOutput("t6_idle", {63'd0, idle}, 64'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      checkOutput("t6_no_rsp", {62'd0, rspV}, 64'd0);
    end
    addr1 = 32'h44;
    applyStimulus(2'b11, 2'b00, 2'b11);
    #1;
    checkOutput("t6_req0_first", {62'd0, reqRdy}, 64'd1);
    step();
    applyStimulus(2'b00, 2'b00, 2'b11);
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
